// File: rtl/dmem_responder.sv
// Data-memory responder: load/store requests served after a fixed LATENCY with
// per-byte write strobes and misalignment/range error reporting.
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_q [DEPTH];

  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_wstrb;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic          commit;
  logic [31:0]   resp_rdata_d;

  // With LATENCY==1 the commit edge is the accept edge, so the access is
  // taken straight from the request inputs rather than the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
    end
    acc_err = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
    acc_idx = acc_addr[AW+1:2];
    commit  = 1'b0;
    if (state_q == IDLE) begin
      commit = req_valid && (LATENCY == 1);
    end else if (state_q == WAIT) begin
      commit = (cnt_q == 4'd1);
    end
    resp_rdata_d = '0;
    if (!acc_we && !acc_err) begin
      resp_rdata_d = mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset && commit && acc_we && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) begin
          mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            cnt_q       <= 4'(LATENCY - 1);
            req_ready_q <= 1'b0;
            if (LATENCY > 1) begin
              state_q <= WAIT;
            end else begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= resp_rdata_d;
              resp_err_q   <= acc_err;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= acc_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=1 instances checked against
// a byte-level memory model with directed and random transactions.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_wstrb  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  logic [31:0] model [2][DEPTH];
  int lat_of [2] = '{2, 1};
  int ncmp = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
  endfunction

  task automatic model_store(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws);
    for (int b = 0; b < 4; b++) begin
      if (ws[b]) model[d][a[31:2]][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic txn(input int d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb,
                     input int hold, output logic [31:0] got);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          edges;
    @(negedge clk);
    check("ready_idle", req_ready[d], 1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wstrb[d] = wstrb;
    exp_err = addr_err(addr);
    exp_rd  = '0;
    if (!we && !exp_err) exp_rd = model[d][addr[31:2]];
    if (we && !exp_err) model_store(d, addr, wdata, wstrb);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    check("ready_drop", req_ready[d], 0);
    edges = 1;
    while (!resp_valid[d] && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check("resp_valid", resp_valid[d], 1);
    check("latency", edges, lat_of[d]);
    check("rdata", resp_rdata[d], exp_rd);
    check("err", resp_err[d], exp_err);
    got = resp_rdata[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", resp_valid[d], 1);
      check("hold_rdata", resp_rdata[d], exp_rd);
      check("hold_err", resp_err[d], exp_err);
      check("hold_ready", req_ready[d], 0);
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check("post_valid", resp_valid[d], 0);
    check("post_ready", req_ready[d], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_we[d] = 0; req_addr[d] = '0;
      req_wdata[d] = '0; req_wstrb[d] = '0; resp_ready[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", req_ready[d], 1);
      check("rst_resp_valid", resp_valid[d], 0);
      check("rst_rdata", resp_rdata[d], 0);
      check("rst_err", resp_err[d], 0);
    end
    reset = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < int'(DEPTH); w++) txn(d, 1, 32'(w * 4), '0, 4'hF, 0, got);

    txn(0, 1, 32'h8, 32'hDEADBEEF, 4'hF, 0, got);
    check("store_rdata_zero", got, 0);
    txn(0, 0, 32'h8, '0, 4'h0, 0, got);
    check("load_deadbeef", got, 32'hDEADBEEF);

    txn(0, 1, 32'h10, 32'h11223344, 4'hF, 0, got);
    txn(0, 1, 32'h10, 32'hAABBCCDD, 4'b0101, 0, got);
    txn(0, 0, 32'h10, '0, 4'h0, 0, got);
    check("byte_strobes", got, 32'h11BB33DD);
    txn(0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, got);
    txn(0, 0, 32'h10, '0, 4'h0, 0, got);
    check("zero_strobe_noop", got, 32'h11BB33DD);

    txn(0, 0, 32'h8, '0, 4'h0, 5, got);

    txn(0, 0, 32'h6, '0, 4'h0, 0, got);
    txn(0, 1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, got);
    txn(0, 0, 32'h0, '0, 4'h0, 0, got);
    check("oor_store_no_write", got, 0);

    // Reset while in WAIT: the store must be dropped.
    @(negedge clk);
    req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h4;
    req_wdata[0] = 32'h12345678; req_wstrb[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midop_valid", resp_valid[0], 0);
    check("midop_ready", req_ready[0], 1);
    repeat (2) begin
      @(negedge clk);
      check("midop_no_resp", resp_valid[0], 0);
    end
    txn(0, 0, 32'h4, '0, 4'h0, 0, got);
    check("midop_no_write", got, 0);

    // Reset while in RESP: the write has already committed.
    @(negedge clk);
    req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h4;
    req_wdata[0] = 32'hCAFEF00D; req_wstrb[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 0;
    @(negedge clk);
    check("postcommit_valid", resp_valid[0], 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("postcommit_cleared", resp_valid[0], 0);
    model_store(0, 32'h4, 32'hCAFEF00D, 4'hF);
    txn(0, 0, 32'h4, '0, 4'h0, 0, got);
    check("postcommit_kept", got, 32'hCAFEF00D);

    txn(1, 1, 32'h20, 32'h5A5AA5A5, 4'hF, 0, got);
    @(negedge clk);
    req_valid[1] = 1; req_we[1] = 0; req_addr[1] = 32'h20; resp_ready[1] = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("l1_valid_pattern", resp_valid[1], (i % 2 == 0) ? 1 : 0);
      check("l1_ready_pattern", req_ready[1], (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 0) check("l1_rdata", resp_rdata[1], 32'h5A5AA5A5);
    end
    req_valid[1] = 0;
    resp_ready[1] = 0;

    for (int n = 0; n < 60; n++) begin
      int d;
      d = int'($urandom_range(1, 0));
      a = 32'($urandom_range(69, 0)) * 4;
      if ($urandom_range(7, 0) == 0) a = a | 32'($urandom_range(3, 1));
      txn(d, 1'($urandom_range(1, 0)), a, $urandom, 4'($urandom_range(15, 0)),
          int'($urandom_range(3, 0)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
